// File: rtl/minibus_slave_csr_bank.sv
// Minibus slave CSR bank: parametrised bank of 32-bit registers with wait states,
// read-only / write-1-to-clear attributes, hardware update ports and error responses.
module minibus_slave_csr_bank #(
  parameter int unsigned                     REGS_COUNT  = 8,
  parameter int unsigned                     ADDR_WIDTH  = 32,
  parameter int unsigned                     WAIT_CYCLES = 0,
  parameter logic [REGS_COUNT-1:0]           RO_MASK     = '0,
  parameter logic [REGS_COUNT-1:0]           W1C_MASK    = '0,
  parameter logic [REGS_COUNT-1:0][31:0]     RESET_VALUE = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               sel,
  input  logic                               req_wen,
  input  logic                               req_ren,
  input  logic [1:0]                         req_width,
  input  logic [ADDR_WIDTH-1:0]              req_addr,
  input  logic [31:0]                        req_wdata,
  output logic                               res_ack,
  output logic                               res_err,
  output logic [31:0]                        res_rdata,
  input  logic [REGS_COUNT-1:0]              hw_set,
  input  logic [REGS_COUNT-1:0][31:0]        hw_in,
  output logic [REGS_COUNT-1:0][31:0]        regs_out,
  output logic [REGS_COUNT-1:0]              wr_pulse
);

  localparam int unsigned DATA_WIDTH = 32;
  localparam logic [1:0]  ST_IDLE    = 2'd0;
  localparam logic [1:0]  ST_WAIT    = 2'd1;
  localparam logic [1:0]  ST_RESP    = 2'd2;
  localparam int unsigned CNT_W      = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  logic [1:0]                           state_r;
  logic [CNT_W-1:0]                     cnt_r;
  logic                                 wen_r, ren_r;
  logic [1:0]                           width_r;
  logic [ADDR_WIDTH-1:0]                addr_r;
  logic [DATA_WIDTH-1:0]                wdata_r;
  logic [REGS_COUNT-1:0][DATA_WIDTH-1:0] regs_r;
  logic                                 ack_r, err_r;
  logic [DATA_WIDTH-1:0]                rdata_r;
  logic [REGS_COUNT-1:0]                wp_r;

  logic                                 start_s, commit_s, err_s, misalign_s, ro_hit_s, bus_wr_s;
  logic                                 src_wen_s, src_ren_s;
  logic [1:0]                           src_width_s;
  logic [ADDR_WIDTH-1:0]                src_addr_s, idx_s;
  logic [DATA_WIDTH-1:0]                src_wdata_s, base_mask_s, lane_mask_s, lane_data_s;
  logic [DATA_WIDTH-1:0]                rd_word_s, rd_val_s;
  logic [4:0]                           sh_s;
  logic [REGS_COUNT-1:0]                hit_s, wr_hit_s;
  logic [REGS_COUNT-1:0][DATA_WIDTH-1:0] regs_nxt_s;

  assign start_s = sel & (req_wen | req_ren);

  // Request decode; with no wait states the commit edge is the capture edge, so decode live inputs
  always_comb begin
    if (state_r == ST_IDLE) begin
      src_wen_s   = req_wen;
      src_ren_s   = req_ren;
      src_width_s = req_width;
      src_addr_s  = req_addr;
      src_wdata_s = req_wdata;
    end else begin
      src_wen_s   = wen_r;
      src_ren_s   = ren_r;
      src_width_s = width_r;
      src_addr_s  = addr_r;
      src_wdata_s = wdata_r;
    end

    case (src_width_s)
      2'b00: begin
        base_mask_s = 32'h0000_00FF;
        sh_s        = {src_addr_s[1:0], 3'b000};
      end
      2'b01: begin
        base_mask_s = 32'h0000_FFFF;
        sh_s        = {src_addr_s[1], 4'b0000};
      end
      2'b10: begin
        base_mask_s = 32'hFFFF_FFFF;
        sh_s        = 5'd0;
      end
      default: begin
        base_mask_s = 32'h0000_0000;
        sh_s        = 5'd0;
      end
    endcase
    lane_mask_s = base_mask_s << sh_s;
    lane_data_s = (src_wdata_s << sh_s) & lane_mask_s;

    idx_s     = {2'b00, src_addr_s[ADDR_WIDTH-1:2]};
    rd_word_s = '0;
    ro_hit_s  = 1'b0;
    for (int i = 0; i < int'(REGS_COUNT); i++) begin
      hit_s[i]  = (idx_s == ADDR_WIDTH'(i));
      rd_word_s = rd_word_s | (hit_s[i] ? regs_r[i] : '0);
      ro_hit_s  = ro_hit_s | (hit_s[i] & RO_MASK[i]);
    end
    rd_val_s = (rd_word_s >> sh_s) & base_mask_s;

    misalign_s = ((src_width_s == 2'b01) & src_addr_s[0]) |
                 ((src_width_s == 2'b10) & (src_addr_s[1:0] != 2'b00));
    err_s = (src_wen_s & src_ren_s) | (src_width_s == 2'b11) | misalign_s |
            (idx_s >= ADDR_WIDTH'(REGS_COUNT)) | (src_wen_s & ro_hit_s);

    case (state_r)
      ST_IDLE: commit_s = start_s & (WAIT_CYCLES == 0);
      ST_WAIT: commit_s = sel & (cnt_r == '0);
      default: commit_s = 1'b0;
    endcase
    bus_wr_s = commit_s & src_wen_s & ~err_s;
    wr_hit_s = hit_s & {REGS_COUNT{bus_wr_s}};
  end

  // Next register contents: bus writes beat hardware loads, except W1C where set wins over clear
  always_comb begin
    for (int i = 0; i < int'(REGS_COUNT); i++) begin
      if (wr_hit_s[i] && W1C_MASK[i]) begin
        regs_nxt_s[i] = (regs_r[i] & ~lane_data_s) | (hw_set[i] ? hw_in[i] : '0);
      end else if (wr_hit_s[i]) begin
        regs_nxt_s[i] = (regs_r[i] & ~lane_mask_s) | lane_data_s;
      end else if (hw_set[i] && W1C_MASK[i]) begin
        regs_nxt_s[i] = regs_r[i] | hw_in[i];
      end else if (hw_set[i]) begin
        regs_nxt_s[i] = hw_in[i];
      end else begin
        regs_nxt_s[i] = regs_r[i];
      end
    end
  end

  // Transaction FSM with request capture and wait-state counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      wen_r   <= 1'b0;
      ren_r   <= 1'b0;
      width_r <= 2'b00;
      addr_r  <= '0;
      wdata_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            wen_r   <= req_wen;
            ren_r   <= req_ren;
            width_r <= req_width;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
            cnt_r   <= CNT_LOAD;
            state_r <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!sel) begin
            state_r <= ST_IDLE;
          end else if (cnt_r == '0) begin
            state_r <= ST_RESP;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        ST_RESP: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Register file and registered response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_r  <= RESET_VALUE;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= '0;
      wp_r    <= '0;
    end else begin
      regs_r  <= regs_nxt_s;
      ack_r   <= commit_s;
      err_r   <= commit_s & err_s;
      rdata_r <= (commit_s & src_ren_s & ~err_s) ? rd_val_s : '0;
      wp_r    <= wr_hit_s;
    end
  end

  assign res_ack   = ack_r;
  assign res_err   = err_r;
  assign res_rdata = rdata_r;
  assign regs_out  = regs_r;
  assign wr_pulse  = wp_r;

endmodule

// File: doc/minibus_slave_csr_bank.md
# minibus_slave_csr_bank

Parametrised minibus slave control/status register bank, the successor to the fixed generic slave register array. Adds configurable register count and address width, programmable wait states, per-register read-only and write-1-to-clear attributes, hardware-side update ports, and full error reporting for bad width, misalignment, out-of-range and read-only writes. Sits behind the minibus decoder as the standard CSR block for peripherals. Register data width is fixed at 32 bits (`DATA_WIDTH`).

## Interface
- `REGS_COUNT`, 8: number of 32-bit registers, ≥1.
- `ADDR_WIDTH`, 32: width of `req_addr`.
- `WAIT_CYCLES`, 0: extra cycles between request capture and response.
- `RO_MASK`, '0 (`REGS_COUNT` bits): bit i set means register i is bus read-only.
- `W1C_MASK`, '0 (`REGS_COUNT` bits): bit i set means bus writes to register i clear the written bits.
- `RESET_VALUE`, '0 (`[REGS_COUNT-1:0][31:0]`): per-register reset contents.
- Clocking: one clock; reset is synchronous and active-high.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: synchronous active-high reset.
- `sel` in 1: slave selected.
- `req_wen` in 1: write request.
- `req_ren` in 1: read request.
- `req_width` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_addr` in `ADDR_WIDTH`: byte address.
- `req_wdata` in 32: write data, right-justified for byte/half.
- `res_ack` out 1: one-cycle response strobe.
- `res_err` out 1: error flag, valid with `res_ack`.
- `res_rdata` out 32: read data, valid with `res_ack`.
- `hw_set` in `REGS_COUNT`: hardware update strobe per register.
- `hw_in` in `[REGS_COUNT-1:0][32]`: hardware update data.
- `regs_out` out `[REGS_COUNT-1:0][32]`: current register contents.
- `wr_pulse` out `REGS_COUNT`: one-cycle pulse when a bus write commits to register i.

## Operation
- FSM states IDLE, WAIT, RESP. Reset → IDLE.
- IDLE: `sel & (req_wen | req_ren)` captures addr, width, wdata and op, then goes to WAIT if `WAIT_CYCLES>0`, else RESP. `sel` with neither enable is ignored.
- WAIT: counter loads `WAIT_CYCLES-1` and decrements; goes to RESP at 0. If `sel` drops during WAIT: abort to IDLE with no commit and no ack.
- RESP: `res_ack=1` for exactly one cycle, then unconditional IDLE. The next request may be captured on the following IDLE cycle.
- Commit (register update, `rdata` capture, `wr_pulse`) happens on the edge that enters RESP.
- Index = `addr[ADDR_WIDTH-1:2]`. Errors, checked in priority order:
  - `wen & ren`
  - width 11
  - half with `addr[0]=1`, or word with `addr[1:0]≠0`
  - index ≥ `REGS_COUNT`
  - write to an `RO_MASK` register
- On error: `res_err=1`, `res_rdata=0`, no register change, no `wr_pulse`.
- Write lanes: byte lane = `addr[1:0]`, half lane = `addr[1]`. Normal registers merge the lanes. W1C registers do `reg &= ~lane_data` on written lanes only.
- Read: byte/half returned zero-extended in bits [7:0]/[15:0]. Reads have no side effects.
- `hw_set[i]`:
  - Normal and RO registers: `reg = hw_in[i]`.
  - W1C registers: `reg |= hw_in[i]`.
- Same-cycle `hw_set` and bus commit to the same register:
  - Normal: bus write wins.
  - W1C: `reg = (reg & ~clr) | hw_in`, so set wins.
- `regs_out` is the registered contents.

## Timing
- Reset values: regs = `RESET_VALUE`, state IDLE, `res_ack=0`, `res_err=0`, `res_rdata=0`, `wr_pulse=0`.
- Request sampled in cycle N; `res_ack` in cycle N+1+`WAIT_CYCLES`.
- `wr_pulse`, the register update and `regs_out` change are visible in the ack cycle.
- `res_err`/`res_rdata` are registered and held 0 outside the ack cycle.
- `rst` asserted in any state: next cycle is IDLE with reset values. Any in-flight transaction is dropped and no ack is issued.
- The master holds `sel` and request fields until ack; changes after capture are ignored except `sel` deassert in WAIT.

## Test plan
- Reset with `RESET_VALUE[2]=0xDEADBEEF`, word read at addr 0x8 → ack next cycle, `rdata=0xDEADBEEF`, `err=0`.
- reg1=0x11223344, byte write 0xAB at addr 0x5 → reg1=0x1122AB44, `wr_pulse=8'b00000010` for one cycle. Half read at addr 0x6 → 0x00001122.
- reg3 W1C holding 0x000000FF, word write 0x0000000F with `hw_set[3]`, `hw_in=0x100` in the commit cycle → reg3=0x000001F0.
- `REGS_COUNT=8`: width 11; half at 0x3; word read at 0x20; write to an RO register → each gives ack with `err=1`, `rdata=0`, registers unchanged.
- `WAIT_CYCLES=3`: request at cycle 0 → ack at cycle 4. Repeat with `sel` dropped at cycle 2 → no ack, no commit.
- `rst` pulsed during WAIT of a write to reg0 → no ack, reg0=`RESET_VALUE[0]`. A fresh request is accepted the cycle after reset is released.
